// File: rtl/fifo_serial_tx_pkg.sv
// Shared definitions for fifo_serial_tx: FSM state encoding and counter width helper.
package fifo_serial_tx_pkg;

   localparam int unsigned STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_LOAD   = 3'd2,
      ST_START  = 3'd3,
      ST_DATA   = 3'd4,
      ST_PARITY = 3'd5,
      ST_STOP   = 3'd6
   } state_t;

   // Bits needed to count 0..n-1, never less than one.
   function automatic int unsigned cnt_width(input int unsigned n);
      int unsigned w;
      w = 1;
      while ((32'd1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/fifo_serial_tx_if.sv
// FIFO read port as seen by its consumer (master) and by the FIFO (slave).
interface fifo_serial_tx_if #(
   parameter int unsigned DATA_W = 8
);
   logic              fifo_empty;
   logic              fifo_rd_en;
   logic [DATA_W-1:0] fifo_dout;

   modport master (input fifo_empty, input fifo_dout, output fifo_rd_en);
   modport slave  (output fifo_empty, output fifo_dout, input fifo_rd_en);
endinterface

// File: rtl/fifo_serial_tx_baud_tick_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, synchronous clear, registered end-of-bit pulse.
module baud_tick_gen
   import fifo_serial_tx_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic bit_end,
   output logic last_next_c
);

   localparam int unsigned       CNT_W   = cnt_width(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0]  CNT_PEN = CNT_W'(CLKS_PER_BIT - 2);

   logic [CNT_W-1:0] cnt_q;

   // High when the coming cycle is the last one of the current bit period.
   assign last_next_c = !clear && !bit_end && (cnt_q == CNT_PEN);

   // Counter and end-of-bit flag; a wrap or clear both restart at zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q   <= '0;
         bit_end <= 1'b0;
      end else begin
         bit_end <= last_next_c;
         if (clear || bit_end) cnt_q <= '0;
         else                  cnt_q <= cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/fifo_serial_tx.sv
// FIFO-draining serial transmitter: start bit, DATA_W bits LSB first, optional even parity, stop bit(s).
// Build option: define FIFO_SERIAL_TX_PARITY_EN to add a parity bit between data and stop.
module fifo_serial_tx
   import fifo_serial_tx_pkg::*;
#(
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   fifo_serial_tx_if.master    fifo,
   output logic                tx,
   output logic                busy,
   output logic                byte_done
);

   localparam int unsigned       BIT_W     = cnt_width(DATA_W);
   localparam int unsigned       STOP_W    = cnt_width(STOP_BITS);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
   localparam logic [STOP_W-1:0] STOP_LAST = STOP_W'(STOP_BITS - 1);

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic [BIT_W-1:0]    bit_q, bit_d;
   logic [STOP_W-1:0]   stop_q, stop_d;
   logic                tx_d, busy_d, rd_en_d, done_d;
   logic                clear_c, bit_end, last_next_c;
`ifdef FIFO_SERIAL_TX_PARITY_EN
   logic                par_q, par_d;
`endif

   baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk         (clk),
      .rst         (rst),
      .clear       (clear_c),
      .bit_end     (bit_end),
      .last_next_c (last_next_c)
   );

   // Next state, datapath updates and next values of the registered outputs.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      bit_d   = bit_q;
      stop_d  = stop_q;
`ifdef FIFO_SERIAL_TX_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         ST_IDLE:  if (enable && !fifo.fifo_empty) state_d = ST_FETCH;
         ST_FETCH: state_d = ST_LOAD;
         ST_LOAD: begin
            shift_d = fifo.fifo_dout;
`ifdef FIFO_SERIAL_TX_PARITY_EN
            par_d   = ^fifo.fifo_dout;
`endif
            state_d = ST_START;
         end
         ST_START: if (bit_end) begin
            state_d = ST_DATA;
            bit_d   = '0;
         end
         ST_DATA: if (bit_end) begin
            if (bit_q == BIT_LAST) begin
`ifdef FIFO_SERIAL_TX_PARITY_EN
               state_d = ST_PARITY;
`else
               state_d = ST_STOP;
               stop_d  = '0;
`endif
            end else begin
               bit_d   = bit_q + BIT_W'(1);
               shift_d = shift_q >> 1;
            end
         end
`ifdef FIFO_SERIAL_TX_PARITY_EN
         ST_PARITY: if (bit_end) begin
            state_d = ST_STOP;
            stop_d  = '0;
         end
`endif
         ST_STOP: if (bit_end) begin
            if (stop_q == STOP_LAST) state_d = ST_IDLE;
            else                     stop_d  = stop_q + STOP_W'(1);
         end
         default: state_d = ST_IDLE;
      endcase

      // Every state entry restarts the bit-period counter.
      clear_c = (state_d != state_q);

      rd_en_d = (state_d == ST_FETCH);
      busy_d  = (state_d != ST_IDLE);
      done_d  = (state_d == ST_STOP) && (stop_d == STOP_LAST) && last_next_c;

      case (state_d)
         ST_START:  tx_d = 1'b0;
         ST_DATA:   tx_d = shift_d[0];
`ifdef FIFO_SERIAL_TX_PARITY_EN
         ST_PARITY: tx_d = par_q;
`endif
         default:   tx_d = 1'b1;
      endcase
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q         <= ST_IDLE;
         shift_q         <= '0;
         bit_q           <= '0;
         stop_q          <= '0;
         tx              <= 1'b1;
         busy            <= 1'b0;
         byte_done       <= 1'b0;
         fifo.fifo_rd_en <= 1'b0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
         par_q           <= 1'b0;
`endif
      end else begin
         state_q         <= state_d;
         shift_q         <= shift_d;
         bit_q           <= bit_d;
         stop_q          <= stop_d;
         tx              <= tx_d;
         busy            <= busy_d;
         byte_done       <= done_d;
         fifo.fifo_rd_en <= rd_en_d;
`ifdef FIFO_SERIAL_TX_PARITY_EN
         par_q           <= par_d;
`endif
      end
   end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Directed bench for fifo_serial_tx with a small behavioural FIFO on the read port.
module tb_fifo_serial_tx;

   localparam int CPB = 4;
`ifdef FIFO_SERIAL_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   logic clk = 1'b0;
   logic rst;
   logic enable;
   logic tx, busy, byte_done;

   int n_checks = 0;
   int n_errors = 0;

   fifo_serial_tx_if #(.DATA_W(8)) fifo_bus ();

   fifo_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .fifo      (fifo_bus),
      .tx        (tx),
      .busy      (busy),
      .byte_done (byte_done)
   );

   always #20 clk = ~clk;

   // Behavioural FIFO: pushed by the stimulus, popped by the DUT read strobe.
   logic [7:0]  mem [0:63];
   int unsigned wr_ptr = 0;
   int unsigned rd_ptr = 0;

   assign fifo_bus.fifo_empty = (wr_ptr == rd_ptr);

   always @(posedge clk) begin
      if (fifo_bus.fifo_rd_en && (wr_ptr != rd_ptr)) begin
         fifo_bus.fifo_dout <= mem[rd_ptr[5:0]];
         rd_ptr             <= rd_ptr + 1;
      end
   end

   // Pulse counters and read-while-empty watch.
   int rd_cnt = 0, done_cnt = 0, viol = 0;
   always @(negedge clk) begin
      if (fifo_bus.fifo_rd_en === 1'b1) rd_cnt++;
      if (fifo_bus.fifo_rd_en === 1'b1 && fifo_bus.fifo_empty) viol++;
      if (byte_done === 1'b1) done_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [7:0] d);
      mem[wr_ptr[5:0]] = d;
      wr_ptr++;
   endtask

   function automatic logic [15:0] exp_frame(input logic [7:0] d);
      logic [15:0] f;
      f      = '0;
      f[0]   = 1'b0;
      f[8:1] = d;
`ifdef FIFO_SERIAL_TX_PARITY_EN
      f[9]   = ^d;
      f[10]  = 1'b1;
`else
      f[9]   = 1'b1;
`endif
      return f;
   endfunction

   // Waits (bounded) for a start bit, then samples one whole frame on falling edges.
   task automatic capture(output logic [15:0] bits, output int gap, output int didx,
                          output bit stable, output bit got);
      bits = '0; gap = 0; didx = -1; stable = 1'b1; got = 1'b0;
      for (int w = 0; w < 300 && !got; w++) begin
         @(negedge clk);
         if (tx === 1'b0) got = 1'b1;
         else             gap++;
      end
      if (!got) return;
      for (int i = 0; i < NB * CPB; i++) begin
         if (i > 0) @(negedge clk);
         if (i % CPB == 0)              bits[i / CPB] = tx;
         else if (tx !== bits[i / CPB]) stable = 1'b0;
         if (byte_done === 1'b1 && didx < 0) didx = i;
      end
   endtask

   task automatic check_frame(input string tag, input logic [7:0] d, output int gap);
      logic [15:0] bits;
      int          didx;
      bit          stable, got;
      capture(bits, gap, didx, stable, got);
      check({tag, "_start"}, 32'(got), 32'd1);
      check({tag, "_bits"}, 32'(bits), 32'(exp_frame(d)));
      check({tag, "_stable"}, 32'(stable), 32'd1);
      check({tag, "_done_at"}, 32'(didx), 32'(NB * CPB - 1));
   endtask

   initial begin
      int gap, base_rd, base_done;

      // Reset held with data waiting and enable high.
      rst = 1'b0;
      enable = 1'b1;
      push(8'hA5);
      repeat (3) @(negedge clk);
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rd_en", 32'(fifo_bus.fifo_rd_en), 32'd0);
      check("rst_done", 32'(byte_done), 32'd0);

      // Release: one IDLE decision, then the read strobe.
      rst = 1'b1;
      @(negedge clk);
      check("first_rd_en", 32'(fifo_bus.fifo_rd_en), 32'd1);
      check("first_busy", 32'(busy), 32'd1);
      check_frame("a5", 8'hA5, gap);
      repeat (4) @(negedge clk);
      check("a5_rd_cnt", 32'(rd_cnt), 32'd1);
      check("a5_done_cnt", 32'(done_cnt), 32'd1);
      check("a5_idle_busy", 32'(busy), 32'd0);
      check("a5_idle_tx", 32'(tx), 32'd1);

      // Fifteen queued bytes drained back to back.
      base_rd = rd_cnt;
      base_done = done_cnt;
      for (int i = 1; i <= 15; i++) push(8'(i));
      for (int i = 1; i <= 15; i++) begin
         check_frame("burst", 8'(i), gap);
         if (i > 1) check("burst_gap", 32'(gap), 32'd3);
      end
      repeat (4) @(negedge clk);
      check("burst_rd_cnt", 32'(rd_cnt - base_rd), 32'd15);
      check("burst_done_cnt", 32'(done_cnt - base_done), 32'd15);
      check("burst_busy", 32'(busy), 32'd0);

      // Enable dropped during the second of four queued frames.
      enable = 1'b0;
      push(8'h11); push(8'h12); push(8'h3C); push(8'h55);
      repeat (3) @(negedge clk);
      check("hold_busy", 32'(busy), 32'd0);
      check("hold_rd_cnt", 32'(rd_cnt - base_rd), 32'd15);
      base_rd = rd_cnt;
      base_done = done_cnt;
      enable = 1'b1;
      check_frame("en1", 8'h11, gap);
      repeat (2) @(negedge clk);
      check("en2_busy", 32'(busy), 32'd1);
      repeat (10) @(negedge clk);
      enable = 1'b0;
      repeat (60) @(negedge clk);
      check("en_rd_cnt", 32'(rd_cnt - base_rd), 32'd2);
      check("en_done_cnt", 32'(done_cnt - base_done), 32'd2);
      check("en_tx", 32'(tx), 32'd1);
      check("en_busy", 32'(busy), 32'd0);

      // Asynchronous reset during the data bits of 8'h3C.
      enable = 1'b1;
      begin
         bit seen;
         seen = 1'b0;
         for (int w = 0; w < 300 && !seen; w++) begin
            @(negedge clk);
            if (tx === 1'b0) seen = 1'b1;
         end
         check("r3c_start", 32'(seen), 32'd1);
      end
      repeat (5) @(negedge clk);
      check("r3c_pre_tx", 32'(tx), 32'd0);
      check("r3c_pre_busy", 32'(busy), 32'd1);
      rst = 1'b0;
      #1;
      check("r3c_rst_tx", 32'(tx), 32'd1);
      check("r3c_rst_busy", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      check_frame("after_rst", 8'h55, gap);

      // Parity-sensitive bytes: odd and even number of ones.
      repeat (3) @(negedge clk);
      push(8'h07);
      check_frame("b07", 8'h07, gap);
      push(8'h03);
      check_frame("b03", 8'h03, gap);

      repeat (4) @(negedge clk);
      check("rd_while_empty", 32'(viol), 32'd0);
      check("end_busy", 32'(busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
